stage_ctrl: RTL and testbench

STAGE_CTRL -- requirements
Module: stage_ctrl

---
 rtl/stage_ctrl_if.sv | 25 ++
 rtl/stage_ctrl.sv | 148 ++++++++++++++
 tb/tb_stage_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/stage_ctrl_if.sv
// Controller-side bundle: instruction/class inputs, memory handshake and stage/strobe outputs.
// master = the stage controller, slave = the datapath/memory environment that drives it.
interface stage_ctrl_if;
    logic [31:0] ir_i;
    logic [4:0]  itype_i;
    logic        mem_ack_i;
    logic [2:0]  stage_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        ir_we_o;
    logic        pc_we_o;
    logic        wd_q_o;
    logic        fault_o;
    logic [31:0] instret_o;

    modport master (
        input  ir_i, itype_i, mem_ack_i,
        output stage_o, mem_req_o, mem_we_o, ir_we_o, pc_we_o, wd_q_o, fault_o, instret_o
    );

    modport slave (
        output ir_i, itype_i, mem_ack_i,
        input  stage_o, mem_req_o, mem_we_o, ir_we_o, pc_we_o, wd_q_o, fault_o, instret_o
    );
endinterface

// File: rtl/stage_ctrl.sv
// Multicycle instruction stage sequencer (Moore): IF/ID/EX/MEM/WB with a 16-cycle memory watchdog.
// Latency R/I/U/J 4, load 5, store 4, branch 3 cycles; IF and MEM hold mem_req_o until mem_ack_i.
module stage_ctrl (
    input  logic         clk,
    input  logic         reset,
    stage_ctrl_if.master bus
);
    // Instruction class codes shared with the decoder.
    localparam logic [4:0] RTYPE  = 5'd1;
    localparam logic [4:0] ITYPE  = 5'd2;
    localparam logic [4:0] STYPE  = 5'd3;
    localparam logic [4:0] BTYPE  = 5'd4;
    localparam logic [4:0] LTYPE  = 5'd5;
    localparam logic [4:0] UTYPE  = 5'd6;
    localparam logic [4:0] JTYPE  = 5'd7;
    localparam logic [4:0] JRTYPE = 5'd8;

    // MEM and WB are split so mem_we_o and wd_q_o decode purely from state.
    typedef enum logic [3:0] {
        S_RST, S_IF, S_ID, S_EX, S_MEM_LD, S_MEM_ST, S_WB_WR, S_WB_NW, S_FAULT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait;
    logic [3:0]  w_wait_nxt;
    logic [31:0] r_instret;
    logic        r_pc_we;
    logic        w_retire;
    logic        w_rd_nz;
    logic        w_unused;

    assign w_rd_nz  = |bus.ir_i[11:7];
    assign w_unused = ^{bus.ir_i[31:12], bus.ir_i[6:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_RST;
            r_wait    <= 4'd0;
            r_instret <= 32'd0;
            r_pc_we   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_wait    <= w_wait_nxt;
            r_instret <= r_instret + {31'd0, w_retire};
            r_pc_we   <= w_retire;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait;
        w_retire   = 1'b0;
        case (r_state)
            S_RST: begin
                w_next     = S_IF;
                w_wait_nxt = 4'd0;
            end
            S_IF: begin
                if (bus.mem_ack_i)        w_next = S_ID;
                else if (r_wait == 4'hF)  w_next = S_FAULT;
                else                      w_wait_nxt = r_wait + 4'd1;
            end
            S_ID: w_next = S_EX;
            S_EX: begin
                w_wait_nxt = 4'd0;
                case (bus.itype_i)
                    LTYPE:  w_next = S_MEM_LD;
                    STYPE:  w_next = S_MEM_ST;
                    BTYPE: begin
                        w_next   = S_IF;
                        w_retire = 1'b1;
                    end
                    RTYPE, ITYPE, UTYPE, JTYPE, JRTYPE:
                        w_next = w_rd_nz ? S_WB_WR : S_WB_NW;
                    default: w_next = S_FAULT;
                endcase
            end
            S_MEM_LD: begin
                if (bus.mem_ack_i)        w_next = w_rd_nz ? S_WB_WR : S_WB_NW;
                else if (r_wait == 4'hF)  w_next = S_FAULT;
                else                      w_wait_nxt = r_wait + 4'd1;
            end
            S_MEM_ST: begin
                if (bus.mem_ack_i) begin
                    w_next     = S_IF;
                    w_wait_nxt = 4'd0;
                    w_retire   = 1'b1;
                end else if (r_wait == 4'hF) begin
                    w_next = S_FAULT;
                end else begin
                    w_wait_nxt = r_wait + 4'd1;
                end
            end
            S_WB_WR, S_WB_NW: begin
                w_next     = S_IF;
                w_wait_nxt = 4'd0;
                w_retire   = 1'b1;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    always_comb begin
        bus.stage_o   = 3'd7;
        bus.mem_req_o = 1'b0;
        bus.mem_we_o  = 1'b0;
        bus.ir_we_o   = 1'b0;
        bus.wd_q_o    = 1'b0;
        bus.fault_o   = 1'b0;
        case (r_state)
            S_RST:    bus.stage_o = 3'd7;
            S_IF: begin
                bus.stage_o   = 3'd0;
                bus.mem_req_o = 1'b1;
            end
            S_ID: begin
                bus.stage_o = 3'd1;
                bus.ir_we_o = 1'b1;
            end
            S_EX:     bus.stage_o = 3'd2;
            S_MEM_LD: begin
                bus.stage_o   = 3'd3;
                bus.mem_req_o = 1'b1;
            end
            S_MEM_ST: begin
                bus.stage_o   = 3'd3;
                bus.mem_req_o = 1'b1;
                bus.mem_we_o  = 1'b1;
            end
            S_WB_WR: begin
                bus.stage_o = 3'd4;
                bus.wd_q_o  = 1'b1;
            end
            S_WB_NW:  bus.stage_o = 3'd4;
            S_FAULT: begin
                bus.stage_o = 3'd5;
                bus.fault_o = 1'b1;
            end
            default:  bus.stage_o = 3'd7;
        endcase
    end

    // PC advance is registered off the retirement edge, so it lands in the following IF cycle.
    assign bus.pc_we_o   = r_pc_we;
    assign bus.instret_o = r_instret;
endmodule

// File: tb/tb_stage_ctrl.sv
// Randomized bench: per-instruction expected cycle schedules built from the stage rules, compared each cycle.
module tb_stage_ctrl;
    localparam logic [4:0] RTYPE  = 5'd1;
    localparam logic [4:0] ITYPE  = 5'd2;
    localparam logic [4:0] STYPE  = 5'd3;
    localparam logic [4:0] BTYPE  = 5'd4;
    localparam logic [4:0] LTYPE  = 5'd5;
    localparam logic [4:0] UTYPE  = 5'd6;
    localparam logic [4:0] JTYPE  = 5'd7;
    localparam logic [4:0] JRTYPE = 5'd8;

    typedef struct {
        logic [2:0]  stage;
        bit          req, we, irwe, wdq, flt, ack, ret;
        logic [31:0] ir;
        logic [4:0]  ity;
    } cyc_t;

    logic clk;
    logic reset;
    stage_ctrl_if bus();

    stage_ctrl dut (.clk(clk), .reset(reset), .bus(bus.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    cyc_t        q[$];
    bit          prev_ret;
    logic [31:0] exp_instret;
    logic [31:0] cur_ir;
    logic [4:0]  cur_ity;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input bit req, input bit we, input bit irwe,
                        input bit wdq, input bit flt, input bit ack, input bit ret);
        cyc_t e;
        e.stage = st; e.req = req; e.we = we; e.irwe = irwe; e.wdq = wdq;
        e.flt = flt; e.ack = ack; e.ret = ret; e.ir = cur_ir; e.ity = cur_ity;
        q.push_back(e);
    endtask

    function automatic bit noise();
        return bit'($urandom_range(0, 1));
    endfunction

    // A memory phase acks after d idle cycles; 16 or more idle cycles trip the watchdog.
    task automatic mem_phase(input logic [2:0] st, input bit we, input int d, input bit ret_on_ack,
                             output bit faulted);
        faulted = 1'b0;
        if (d >= 16) begin
            for (int k = 0; k < 16; k++) push(st, 1, we, 0, 0, 0, 0, 0);
            faulted = 1'b1;
        end else begin
            for (int k = 0; k < d; k++) push(st, 1, we, 0, 0, 0, 0, 0);
            push(st, 1, we, 0, 0, 0, 1, ret_on_ack);
        end
    endtask

    task automatic build(input logic [4:0] ity, input logic [4:0] rd, input int d_if,
                         input int d_mem, output bit faulted);
        bit f;
        cur_ir      = $urandom;
        cur_ir[11:7] = rd;
        cur_ity     = ity;
        mem_phase(3'd0, 0, d_if, 0, f);
        faulted = f;
        if (f) return;
        push(3'd1, 0, 0, 1, 0, 0, noise(), 0);
        if (ity == BTYPE) begin
            push(3'd2, 0, 0, 0, 0, 0, noise(), 1);
        end else if (ity == STYPE) begin
            push(3'd2, 0, 0, 0, 0, 0, noise(), 0);
            mem_phase(3'd3, 1, d_mem, 1, f);
            faulted = f;
        end else if (ity == LTYPE) begin
            push(3'd2, 0, 0, 0, 0, 0, noise(), 0);
            mem_phase(3'd3, 0, d_mem, 0, f);
            faulted = f;
            if (!f) push(3'd4, 0, 0, 0, rd != 0, 0, noise(), 1);
        end else if (ity inside {RTYPE, ITYPE, UTYPE, JTYPE, JRTYPE}) begin
            push(3'd2, 0, 0, 0, 0, 0, noise(), 0);
            push(3'd4, 0, 0, 0, rd != 0, 0, noise(), 1);
        end else begin
            push(3'd2, 0, 0, 0, 0, 0, noise(), 0);
            faulted = 1'b1;
        end
    endtask

    task automatic step();
        cyc_t e;
        e = q.pop_front();
        @(negedge clk);
        if (prev_ret) exp_instret++;
        chk("stage",   bus.stage_o,   e.stage);
        chk("mem_req", bus.mem_req_o, e.req);
        chk("mem_we",  bus.mem_we_o,  e.we);
        chk("ir_we",   bus.ir_we_o,   e.irwe);
        chk("wd_q",    bus.wd_q_o,    e.wdq);
        chk("pc_we",   bus.pc_we_o,   prev_ret);
        chk("fault",   bus.fault_o,   e.flt);
        chk("instret", bus.instret_o, exp_instret);
        bus.mem_ack_i = e.ack;
        bus.ir_i      = e.ir;
        bus.itype_i   = e.ity;
        prev_ret      = e.ret;
    endtask

    task automatic run_q();
        while (q.size() > 0) step();
    endtask

    // One edge with reset low, then release; ack_in is presented during the RST cycle.
    task automatic do_reset(input bit ack_in);
        reset = 1'b0;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        chk("rst_stage",   bus.stage_o,   3'd7);
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_strobes", {bus.mem_we_o, bus.ir_we_o, bus.wd_q_o, bus.pc_we_o}, 4'd0);
        chk("rst_fault",   bus.fault_o,   1'b0);
        chk("rst_instret", bus.instret_o, 32'd0);
        reset = 1'b1;
        bus.mem_ack_i = ack_in;
        prev_ret    = 1'b0;
        exp_instret = 32'd0;
    endtask

    task automatic do_instr(input logic [4:0] ity, input logic [4:0] rd, input int d_if, input int d_mem);
        bit f;
        build(ity, rd, d_if, d_mem, f);
        if (f) for (int k = 0; k < 3; k++) push(3'd5, 0, 0, 0, 0, 1, noise(), 0);
        run_q();
        if (f) do_reset(noise());
    endtask

    logic [4:0] valid_types [8];

    initial begin
        bit f;
        logic [4:0] ity;
        int d_if, d_mem;
        valid_types = '{RTYPE, ITYPE, STYPE, BTYPE, LTYPE, UTYPE, JTYPE, JRTYPE};
        reset = 1'b0;
        bus.mem_ack_i = 1'b0;
        bus.ir_i = 32'd0;
        bus.itype_i = 5'd0;
        prev_ret = 1'b0;
        exp_instret = 32'd0;
        cur_ir = 32'd0;
        cur_ity = 5'd0;

        do_reset(1'b0);
        do_instr(RTYPE, 5'd5, 0, 0);
        do_instr(LTYPE, 5'd9, 3, 3);
        do_instr(STYPE, 5'd3, 0, 0);
        do_instr(BTYPE, 5'd0, 0, 0);
        do_instr(ITYPE, 5'd0, 0, 0);
        do_instr(JRTYPE, 5'd1, 15, 0);
        do_instr(STYPE, 5'd2, 0, 15);
        do_instr(LTYPE, 5'd7, 0, 16);
        do_instr(UTYPE, 5'd4, 16, 0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 11) == 0) ity = 5'($urandom_range(9, 31));
            else ity = valid_types[$urandom_range(0, 7)];
            d_if  = ($urandom_range(0, 14) == 0) ? 16 : int'($urandom_range(0, 3));
            d_mem = ($urandom_range(0, 14) == 0) ? 16 : int'($urandom_range(0, 3));
            do_instr(ity, 5'($urandom_range(0, 3)), d_if, d_mem);
        end

        // Reset during a pending MEM access; the ack seen in RST must not advance the fetch.
        do_reset(1'b0);
        build(LTYPE, 5'd6, 0, 10, f);
        for (int k = 0; k < 5; k++) step();
        q.delete();
        do_reset(1'b1);
        do_instr(5'd0, 5'd6, 0, 0);

        do_instr(RTYPE, 5'd8, 1, 0);
        cur_ity = RTYPE;
        push(3'd0, 1, 0, 0, 0, 0, 0, 0);
        run_q();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
